ball_horizontal_gen: RTL and testbench

Parametrised horizontal ball engine for the Pong core, running in the clk7_159 domain. It keeps the ball X position as a register and advances it once per frame by a speed step. The step grows with the paddle-hit count. The block also holds the left/right direction latch and produces the registered ball horizontal video. Added over the fixed-speed discrete version: configurable width, speed levels and ball size; attract-mode edge bounce; and one-clock miss pulses when the ball leaves the playfield.

---
 rtl/ball_horizontal_gen.sv | 130 +++++++++++++
 tb/tb_ball_horizontal_gen.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_horizontal_gen.sv
// Horizontal ball engine for the Pong core: per-frame X motion with hit-scaled
// speed, direction latch, edge bounce/miss handling and registered ball video.
module ball_horizontal_gen #(
  parameter int HW             = 9,
  parameter int BALL_W         = 4,
  parameter int LEFT_LIMIT     = 80,
  parameter int RIGHT_LIMIT    = 440,
  parameter int SERVE_X        = 256,
  parameter int NUM_LEVELS     = 3,
  parameter int HITS_PER_LEVEL = 4,
  parameter int SPEED_BASE     = 1,
  parameter int SPEED_INC      = 1
) (
  input  logic          clk7_159,
  input  logic          _reset,
  input  logic [HW-1:0] hcount,
  input  logic          vreset,
  input  logic          rst_speed,
  input  logic          hit_sound,
  input  logic          _hit1,
  input  logic          _hit2,
  input  logic          sc,
  input  logic          attract,
  input  logic          serve,
  input  logic          _hblank,
  output logic          l,
  output logic          r,
  output logic          _hvid,
  output logic          miss_l,
  output logic          miss_r,
  output logic [HW-1:0] ball_x,
  output logic [2:0]    speed_level
);

  localparam logic [HW:0]   LL   = (HW+1)'(LEFT_LIMIT);
  localparam logic [HW:0]   RL   = (HW+1)'(RIGHT_LIMIT);
  localparam logic [HW:0]   BW   = (HW+1)'(BALL_W);
  localparam logic [HW-1:0] SX   = HW'(SERVE_X);
  localparam logic [5:0]    HPL  = 6'(HITS_PER_LEVEL);
  localparam logic [5:0]    MAXL = 6'(NUM_LEVELS - 1);

  logic [HW-1:0] x_q, x_d;
  logic          dir_l_q, dir_l_d;
  logic [5:0]    hits_q, hits_d;
  logic          hvid_q, hvid_d;
  logic          miss_l_q, miss_l_d, miss_r_q, miss_r_d;
  logic [5:0]    lvl_raw;
  logic [HW:0]   step, x_ext, hc_ext;

  assign lvl_raw     = hits_q / HPL;
  assign speed_level = (lvl_raw > MAXL) ? MAXL[2:0] : lvl_raw[2:0];
  assign step        = (HW+1)'(SPEED_BASE + SPEED_INC * int'(speed_level));
  assign x_ext       = {1'b0, x_q};
  assign hc_ext      = {1'b0, hcount};

  always_comb begin
    dir_l_d  = dir_l_q;
    x_d      = x_q;
    miss_l_d = 1'b0;
    miss_r_d = 1'b0;
    hits_d   = hits_q;

    if (!_hit1 && _hit2)      dir_l_d = 1'b0;
    else if (_hit1 && !_hit2) dir_l_d = 1'b1;

    // The move below sees the direction already updated by this clock's hit;
    // an edge event then overrides that direction.
    if (vreset) begin
      if (serve || attract) begin
        if (!dir_l_d) begin
          if (x_ext + step > RL) begin
            dir_l_d = 1'b1;
            if (attract) x_d = RL[HW-1:0];
            else begin
              x_d      = SX;
              miss_r_d = 1'b1;
            end
          end else begin
            x_d = x_q + step[HW-1:0];
          end
        end else begin
          if (x_ext < LL + step) begin
            dir_l_d = 1'b0;
            if (attract) x_d = LL[HW-1:0];
            else begin
              x_d      = SX;
              miss_l_d = 1'b1;
            end
          end else begin
            x_d = x_q - step[HW-1:0];
          end
        end
      end else begin
        x_d = SX;
      end
    end

    if (rst_speed || sc)                  hits_d = 6'd0;
    else if (hit_sound && hits_q != 6'd63) hits_d = hits_q + 6'd1;

    hvid_d = !(_hblank && (serve || attract) &&
               hc_ext >= x_ext && hc_ext < x_ext + BW);
  end

  always_ff @(posedge clk7_159 or negedge _reset) begin
    if (!_reset) begin
      x_q      <= SX;
      dir_l_q  <= 1'b0;
      hits_q   <= 6'd0;
      hvid_q   <= 1'b1;
      miss_l_q <= 1'b0;
      miss_r_q <= 1'b0;
    end else begin
      x_q      <= x_d;
      dir_l_q  <= dir_l_d;
      hits_q   <= hits_d;
      hvid_q   <= hvid_d;
      miss_l_q <= miss_l_d;
      miss_r_q <= miss_r_d;
    end
  end

  assign ball_x = x_q;
  assign l      = dir_l_q;
  assign r      = ~dir_l_q;
  assign _hvid  = hvid_q;
  assign miss_l = miss_l_q;
  assign miss_r = miss_r_q;

endmodule

// File: tb/tb_ball_horizontal_gen.sv
// Bench for ball_horizontal_gen: behavioural frame model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ball_horizontal_gen;
  localparam int HW             = 9;
  localparam int BALL_W         = 4;
  localparam int LEFT_LIMIT     = 80;
  localparam int RIGHT_LIMIT    = 440;
  localparam int SERVE_X        = 256;
  localparam int NUM_LEVELS     = 3;
  localparam int HITS_PER_LEVEL = 4;
  localparam int SPEED_BASE     = 1;
  localparam int SPEED_INC      = 1;

  logic clk7_159 = 1'b0;
  logic _reset = 1'b1;
  logic [HW-1:0] hcount = '0;
  logic vreset = 0, rst_speed = 0, hit_sound = 0, _hit1 = 1, _hit2 = 1;
  logic sc = 0, attract = 0, serve = 1, _hblank = 1;
  logic l, r, _hvid, miss_l, miss_r;
  logic [HW-1:0] ball_x;
  logic [2:0] speed_level;

  always #5 clk7_159 = ~clk7_159;

  ball_horizontal_gen #(
    .HW(HW), .BALL_W(BALL_W), .LEFT_LIMIT(LEFT_LIMIT), .RIGHT_LIMIT(RIGHT_LIMIT),
    .SERVE_X(SERVE_X), .NUM_LEVELS(NUM_LEVELS), .HITS_PER_LEVEL(HITS_PER_LEVEL),
    .SPEED_BASE(SPEED_BASE), .SPEED_INC(SPEED_INC)
  ) dut (
    .clk7_159(clk7_159), ._reset(_reset), .hcount(hcount), .vreset(vreset),
    .rst_speed(rst_speed), .hit_sound(hit_sound), ._hit1(_hit1), ._hit2(_hit2),
    .sc(sc), .attract(attract), .serve(serve), ._hblank(_hblank),
    .l(l), .r(r), ._hvid(_hvid), .miss_l(miss_l), .miss_r(miss_r),
    .ball_x(ball_x), .speed_level(speed_level)
  );

  int n_chk = 0, n_fail = 0;
  int m_x, m_hits;
  bit m_l, m_hvid, m_missl, m_missr;
  bit chk_en = 0;

  function automatic int m_level();
    int v = m_hits / HITS_PER_LEVEL;
    return (v > NUM_LEVELS - 1) ? NUM_LEVELS - 1 : v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_x = SERVE_X; m_l = 0; m_hits = 0; m_hvid = 1; m_missl = 0; m_missr = 0;
  endtask

  // One clock of the block as described: new direction, then frame move on
  // the ball position held before this edge.
  task automatic model_step();
    int step = SPEED_BASE + SPEED_INC * m_level();
    int hc = int'(hcount);
    bit live = serve || attract;
    m_hvid = !(_hblank && live && hc >= m_x && hc < m_x + BALL_W);
    m_missl = 0; m_missr = 0;
    if (!_hit1 && _hit2) m_l = 0;
    else if (_hit1 && !_hit2) m_l = 1;
    if (vreset) begin
      if (!live) m_x = SERVE_X;
      else if (!m_l) begin
        if (m_x + step > RIGHT_LIMIT) begin
          m_l = 1;
          if (attract) m_x = RIGHT_LIMIT;
          else begin m_x = SERVE_X; m_missr = 1; end
        end else m_x = m_x + step;
      end else begin
        if (m_x < LEFT_LIMIT + step) begin
          m_l = 0;
          if (attract) m_x = LEFT_LIMIT;
          else begin m_x = SERVE_X; m_missl = 1; end
        end else m_x = m_x - step;
      end
    end
    if (rst_speed || sc) m_hits = 0;
    else if (hit_sound && m_hits < 63) m_hits++;
  endtask

  task automatic compare_all();
    chk("ball_x", int'(ball_x), m_x);
    chk("l", int'(l), int'(m_l));
    chk("r", int'(r), int'(!m_l));
    chk("hvid", int'(_hvid), int'(m_hvid));
    chk("miss_l", int'(miss_l), int'(m_missl));
    chk("miss_r", int'(miss_r), int'(m_missr));
    chk("speed_level", int'(speed_level), m_level());
  endtask

  // Compare at the falling edge, advance the model at the rising edge, then
  // return 2 time units later so the caller drives the next inputs.
  task automatic tick();
    @(negedge clk7_159);
    if (chk_en) compare_all();
    @(posedge clk7_159);
    if (_reset) model_step();
    #2;
  endtask

  task automatic frame();
    vreset = 1; tick(); vreset = 0;
  endtask

  task automatic do_reset();
    _reset = 0; model_reset(); tick(); tick(); _reset = 1;
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin hit_sound = 1; tick(); end
    hit_sound = 0;
  endtask

  initial begin
    int lows;
    #1 _reset = 0;
    model_reset();
    chk_en = 1;
    tick();
    chk("rst_ball_x", int'(ball_x), 256);
    chk("rst_r", int'(r), 1);
    chk("rst_l", int'(l), 0);
    chk("rst_hvid", int'(_hvid), 1);
    chk("rst_miss", int'(miss_l | miss_r), 0);
    chk("rst_level", int'(speed_level), 0);
    tick();
    _reset = 1;

    // 1: three frames at step 1
    for (int i = 1; i <= 3; i++) begin
      frame();
      chk("t1_ball_x", int'(ball_x), 256 + i);
    end
    chk("t1_r", int'(r), 1);

    // 2: speed levels
    hits(4);
    chk("t2_level1", int'(speed_level), 1);
    frame();
    chk("t2_step2", int'(ball_x), 261);
    hits(8);
    chk("t2_level_sat", int'(speed_level), 2);
    frame();
    chk("t2_step3", int'(ball_x), 264);

    // 3: direction latch
    do_reset();
    for (int i = 0; i < 44; i++) frame();
    chk("t3_at300", int'(ball_x), 300);
    _hit2 = 0; tick(); _hit2 = 1;
    chk("t3_l", int'(l), 1);
    frame();
    chk("t3_left", int'(ball_x), 299);
    _hit1 = 0; _hit2 = 0; tick(); _hit1 = 1; _hit2 = 1;
    frame();
    chk("t3_both_hold_l", int'(l), 1);
    chk("t3_both_x", int'(ball_x), 298);

    // 4: attract bounce at right edge
    do_reset();
    attract = 1;
    for (int i = 0; i < 183; i++) frame();
    chk("t4_at439", int'(ball_x), 439);
    hits(4);
    frame();
    chk("t4_x", int'(ball_x), 440);
    chk("t4_l", int'(l), 1);
    chk("t4_no_miss", int'(miss_r), 0);
    attract = 0;

    // 5: right miss
    do_reset();
    for (int i = 0; i < 183; i++) frame();
    hits(4);
    frame();
    chk("t5_miss_r", int'(miss_r), 1);
    chk("t5_x", int'(ball_x), 256);
    chk("t5_l", int'(l), 1);
    tick();
    chk("t5_miss_r_drop", int'(miss_r), 0);

    // 6: video sweep
    do_reset();
    lows = 0;
    for (int h = 250; h <= 265; h++) begin
      hcount = HW'(h); tick();
      chk("t6_hvid", int'(_hvid), (h >= 256 && h <= 259) ? 0 : 1);
      if (!_hvid) lows++;
    end
    chk("t6_low_cnt", lows, 4);
    _hblank = 0;
    for (int h = 250; h <= 265; h++) begin
      hcount = HW'(h); tick();
      chk("t6_blank_hvid", int'(_hvid), 1);
    end
    _hblank = 1;
    for (int i = 0; i < 3; i++) frame();
    for (int h = 255; h <= 264; h++) begin
      hcount = HW'(h); tick();
      if (h == 261) begin
        chk("t6_pre_rst_hvid", int'(_hvid), 0);
        _reset = 0; model_reset();
        #1;
        chk("t6_async_hvid", int'(_hvid), 1);
        chk("t6_async_x", int'(ball_x), 256);
        break;
      end
    end
    tick(); _reset = 1;

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      vreset    = ($urandom_range(0, 2) == 0);
      hit_sound = ($urandom_range(0, 7) == 0);
      _hit1     = ($urandom_range(0, 5) != 0);
      _hit2     = ($urandom_range(0, 5) != 0);
      sc        = ($urandom_range(0, 59) == 0);
      rst_speed = ($urandom_range(0, 59) == 0);
      serve     = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 79) == 0) attract = ~attract;
      _hblank   = ($urandom_range(0, 4) != 0);
      hcount    = HW'((m_x + int'($urandom_range(0, 8)) - 3) & ((1 << HW) - 1));
      if ($urandom_range(0, 499) == 0) begin
        _reset = 0; model_reset(); tick(); _reset = 1;
      end else begin
        tick();
      end
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
